debounce_sync: RTL and testbench
================================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive synchronized samples required to accept a level change (legal range 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the counter width, which SHALL satisfy 2**CNT_W >= STABLE_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in1, input, 1 bit: raw, asynchronous, possibly bouncing level (switch or testbench source).
REQ-006 The block SHALL have port out, output, 1 bit: registered, debounced level that feeds the downstream inverter stage.
REQ-007 The block SHALL have port out_n, output, 1 bit: combinational complement of out.
REQ-008 The block SHALL have port rise, output, 1 bit: one-cycle pulse when out goes 0->1.
REQ-009 The block SHALL have port fall, output, 1 bit: one-cycle pulse when out goes 1->0.

Function
REQ-010 in1 SHALL pass through a two-flop synchronizer; its second-stage output is s.
REQ-011 The FSM SHALL have exactly four states: ST_LOW, WAIT_HIGH, ST_HIGH and WAIT_LOW.
REQ-012 In ST_LOW with s=1, the FSM SHALL go to WAIT_HIGH with cnt=1; with s=0 it SHALL stay in ST_LOW with cnt=0.
REQ-013 In WAIT_HIGH with s=0, the FSM SHALL return to ST_LOW with cnt=0, and out, rise and fall SHALL be unchanged/0.
REQ-014 In WAIT_HIGH with s=1 and cnt==STABLE_CYCLES-1, the FSM SHALL go to ST_HIGH with out<=1, rise<=1 and cnt<=0; otherwise cnt SHALL increment.
REQ-015 ST_HIGH and WAIT_LOW SHALL mirror REQ-012..014 with s inverted, giving out<=0 and fall<=1.
REQ-016 rise and fall SHALL be registered, high for exactly one cycle, and never high together.
REQ-017 Latency: with in1 stable from rising edge E0, out SHALL change after edge E0+STABLE_CYCLES+1.
REQ-018 A bounce shorter than STABLE_CYCLES samples SHALL produce no change on out and no pulse.
REQ-019 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL not wrap.
REQ-020 out_n SHALL equal ~out at all times, including during reset.

Reset
REQ-021 On rst_n=0, asynchronously, both synchronizer flops, cnt, out, rise and fall SHALL be 0 and state SHALL be ST_LOW, so out_n=1.
REQ-022 Assertion of rst_n in any state, including mid-WAIT, SHALL discard the partial count.
REQ-023 After rst_n deasserts, no rise or fall pulse SHALL be generated unless a full STABLE_CYCLES qualification completes.

Configuration
REQ-024 With macro DEBOUNCE_EDGE_EN defined, rise and fall SHALL behave per REQ-014..016.
REQ-025 Without DEBOUNCE_EDGE_EN, rise and fall ports SHALL remain present and be tied to 0, with their registers removed.

Structure
REQ-026 The state encoding (ST_LOW=2'b00, WAIT_HIGH=2'b01, ST_HIGH=2'b11, WAIT_LOW=2'b10) and the STABLE_CYCLES default SHALL live in the shared package debounce_pkg.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module sync2 with ports clk, rst_n, d and q, reset to 0.

Verification
REQ-028 The bench SHALL check reset: rst_n=0 with in1=1 -> out=0, out_n=1, rise=0, fall=0 while reset is held.
REQ-029 The bench SHALL check a clean rise: STABLE_CYCLES=4, in1 0->1 sampled at edge 10 -> out=1 after edge 15, rise=1 for the cycle after edge 15 only, out_n=0.
REQ-030 The bench SHALL check bounce rejection: in1 pattern 1,1,0,1,1,0 per cycle from ST_LOW -> out stays 0, no pulse.
REQ-031 The bench SHALL check a clean fall: from ST_HIGH, in1=0 for 10 cycles -> out=0 five edges after the first low sample, fall=1 for one cycle only.
REQ-032 The bench SHALL check reset mid-qualification: rst_n pulsed low while in WAIT_HIGH with cnt=2 -> all outputs 0 immediately; after release with in1=1 -> a full STABLE_CYCLES+2 edges pass before out=1.
REQ-033 The bench SHALL check the build without DEBOUNCE_EDGE_EN: the REQ-029 stimulus -> out identical, rise and fall constant 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce block: FSM state encoding and default
// qualification length.
package debounce_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_LOW    = 2'b00,
    WAIT_HIGH = 2'b01,
    ST_HIGH   = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; both stages clear to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// Debounces a raw asynchronous level: synchronize, then require STABLE_CYCLES
// consecutive equal samples before the registered output follows.
// Optional edge pulses (rise/fall) are built only with DEBOUNCE_EDGE_EN defined.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in1,
  output logic out,
  output logic out_n,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             out_q;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in1),
    .q     (s)
  );

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;
`endif

  // Count restarts at 0 whenever the candidate level drops out, so it never
  // exceeds CNT_LAST and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOW;
      cnt   <= '0;
      out_q <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
    end else begin
`ifdef DEBOUNCE_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      case (state)
        ST_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HIGH;
            cnt   <= '0;
            out_q <= 1'b1;
`ifdef DEBOUNCE_EDGE_EN
            rise_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LOW;
            cnt   <= '0;
            out_q <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            fall_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign out   = out_q;
  assign out_n = ~out_q;

`ifdef DEBOUNCE_EDGE_EN
  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync (STABLE_CYCLES=4); edge-pulse expectations
// follow DEBOUNCE_EDGE_EN so the same file covers both builds.
module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in1;
  logic out, out_n, rise, fall;

  int checks = 0;
  int errors = 0;

  debounce_sync #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (in1),
    .out   (out),
    .out_n (out_n),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns so outputs are sampled off-edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in1   = 1'b1;
    #1;
    checks++;
    if ({out, out_n, rise, fall} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_immediate: got %b want 0100 ({out,out_n,rise,fall})",
               {out, out_n, rise, fall});
    end
    step(6);
    checks++;
    if ({out, out_n, rise, fall} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_held: got %b want 0100", {out, out_n, rise, fall});
    end
    in1   = 1'b0;
    rst_n = 1'b1;
    step(8);
    checks++;
    if ({out, out_n, rise, fall} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_release_idle: got %b want 0100", {out, out_n, rise, fall});
    end
  endtask

  // in1 goes high right after an edge, so the following edge is the first sample.
  task automatic test_clean_rise;
    in1 = 1'b1;
    step(5);
    checks++;
    if ({out, out_n, rise, fall} !== 4'b0100) begin
      errors++;
      $display("FAIL rise_before_latency: got %b want 0100", {out, out_n, rise, fall});
    end
    step(1);
    checks++;
    if ({out, out_n, rise, fall} !== {3'b100, 1'b0} + {2'b00, EDGE_EN, 1'b0}) begin
      errors++;
      $display("FAIL rise_at_latency: got %b want %b", {out, out_n, rise, fall},
               {2'b10, EDGE_EN, 1'b0});
    end
    step(1);
    checks++;
    if ({out, out_n, rise, fall} !== 4'b1000) begin
      errors++;
      $display("FAIL rise_pulse_end: got %b want 1000", {out, out_n, rise, fall});
    end
    step(4);
    checks++;
    if ({out, out_n, rise, fall} !== 4'b1000) begin
      errors++;
      $display("FAIL rise_hold: got %b want 1000", {out, out_n, rise, fall});
    end
  endtask

  task automatic test_clean_fall;
    int pulses;
    in1 = 1'b0;
    step(5);
    checks++;
    if ({out, out_n, rise, fall} !== 4'b1000) begin
      errors++;
      $display("FAIL fall_before_latency: got %b want 1000", {out, out_n, rise, fall});
    end
    step(1);
    checks++;
    if ({out, out_n, rise, fall} !== {3'b010, EDGE_EN}) begin
      errors++;
      $display("FAIL fall_at_latency: got %b want %b", {out, out_n, rise, fall},
               {3'b010, EDGE_EN});
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (fall || rise || out) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL fall_settle: got %0d active cycles want 0", pulses);
    end
  endtask

  task automatic test_bounce;
    logic [5:0] pat;
    int bad;
    pat = 6'b011011;  // applied LSB first: 1,1,0,1,1,0
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      in1 = pat[i];
      step(1);
      if ({out, out_n, rise, fall} !== 4'b0100) bad++;
    end
    in1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if ({out, out_n, rise, fall} !== 4'b0100) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bounce_reject: got %0d disturbed cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    in1 = 1'b1;
    step(4);  // FSM now in WAIT_HIGH with cnt=2
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out, out_n, rise, fall} !== 4'b0100) begin
      errors++;
      $display("FAIL midreset_immediate: got %b want 0100", {out, out_n, rise, fall});
    end
    #1;
    rst_n = 1'b1;
    step(5);
    checks++;
    if ({out, out_n, rise, fall} !== 4'b0100) begin
      errors++;
      $display("FAIL midreset_no_early: got %b want 0100", {out, out_n, rise, fall});
    end
    step(1);
    checks++;
    if ({out, out_n, rise, fall} !== {2'b10, EDGE_EN, 1'b0}) begin
      errors++;
      $display("FAIL midreset_full_qual: got %b want %b", {out, out_n, rise, fall},
               {2'b10, EDGE_EN, 1'b0});
    end
    // Reset from ST_HIGH must clear out without waiting for an edge.
    step(2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out, out_n, rise, fall} !== 4'b0100) begin
      errors++;
      $display("FAIL async_reset_high: got %b want 0100", {out, out_n, rise, fall});
    end
    in1 = 1'b0;
    #1;
    rst_n = 1'b1;
    step(8);
    checks++;
    if ({out, out_n, rise, fall} !== 4'b0100) begin
      errors++;
      $display("FAIL post_reset_quiet: got %b want 0100", {out, out_n, rise, fall});
    end
  endtask

  task automatic test_back_to_back;
    int rises, falls;
    rises = 0;
    falls = 0;
    for (int k = 0; k < 2; k++) begin
      in1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
        step(1);
        rises += int'(rise);
        falls += int'(fall);
      end
      in1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step(1);
        rises += int'(rise);
        falls += int'(fall);
      end
    end
    checks++;
    if (rises !== 2 * int'(EDGE_EN) || falls !== 2 * int'(EDGE_EN)) begin
      errors++;
      $display("FAIL back_to_back_pulses: got rise=%0d fall=%0d want %0d each",
               rises, falls, 2 * int'(EDGE_EN));
    end
    checks++;
    if ({out, out_n} !== 2'b01) begin
      errors++;
      $display("FAIL back_to_back_final: got %b want 01", {out, out_n});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in1   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_bounce();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
